// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-side memory path.
// Used by dcache_wt and dcache_array.
package mips_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } dc_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] idx;
    logic [WORD_W-1:0] tag;
  } addr_split_t;

  // Right-justified index and tag fields of a byte address; callers keep the low bits they need.
  function automatic addr_split_t split_addr(input logic [WORD_W-1:0] addr, input int unsigned idx_w);
    addr_split_t s;
    s.idx = (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
    s.tag = addr >> (idx_w + 2);
    return s;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache.
// Combinational read at idx, synchronous write, asynchronous clear of the valid bits.
module dcache_array
  import mips_mem_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [WORD_W-1:0] rd_data,
  input  logic              fill_en,
  input  logic              data_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [WORD_W-1:0] wr_data
);

  localparam int LINES = 2 ** IDX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  valid_d;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [WORD_W-1:0] data_mem [LINES];

  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag and data need no reset: nothing reads them while the line is invalid.
  always_ff @(posedge clk) begin
    if (fill_en)           tag_mem[idx]  <= wr_tag;
    if (fill_en | data_en) data_mem[idx] <= wr_data;
  end

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache in front of a req/ack memory.
// Optional macro DCACHE_STATS_EN adds hit_cnt/miss_cnt output counters.
module dcache_wt
  import mips_mem_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int TAG_W = 30 - IDX_W;

  addr_split_t        sp;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               unused_bits;

  assign sp          = split_addr(cpu_addr, IDX_W);
  assign idx         = sp.idx[IDX_W-1:0];
  assign tag         = sp.tag[TAG_W-1:0];
  assign unused_bits = ^{sp.idx[WORD_W-1:IDX_W], sp.tag[WORD_W-1:TAG_W]};

  logic              arr_valid;
  logic [TAG_W-1:0]  arr_tag;
  logic [WORD_W-1:0] arr_data;
  logic              hit;
  logic              fill_en;
  logic              data_en;
  logic [WORD_W-1:0] arr_wdata;

  dcache_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk      (clk),
    .reset    (reset),
    .idx      (idx),
    .rd_valid (arr_valid),
    .rd_tag   (arr_tag),
    .rd_data  (arr_data),
    .fill_en  (fill_en),
    .data_en  (data_en),
    .wr_tag   (tag),
    .wr_data  (arr_wdata)
  );

  assign hit = arr_valid & (arr_tag == tag);

  dc_state_t         state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

  // The core holds cpu_addr/cpu_wdata stable while stalled, so idx/tag stay valid for the fill.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_stall   = 1'b0;
    cpu_rdata   = '0;
    fill_en     = 1'b0;
    data_en     = 1'b0;
    arr_wdata   = cpu_wdata;
    case (state_q)
      IDLE: begin
        if (cpu_we) begin
          state_d     = WR_THRU;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {tag, idx, 2'b00};
          mem_wdata_d = cpu_wdata;
          cpu_stall   = 1'b1;
        end else if (cpu_re) begin
          if (hit) begin
            cpu_rdata = arr_data;
          end else begin
            state_d     = RD_MISS;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {tag, idx, 2'b00};
            mem_wdata_d = '0;
            cpu_stall   = 1'b1;
          end
        end
      end
      RD_MISS: begin
        if (mem_ack) begin
          cpu_rdata = mem_rdata;
          arr_wdata = mem_rdata;
          fill_en   = 1'b1;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          cpu_stall = 1'b1;
        end
      end
      WR_THRU: begin
        if (mem_ack) begin
          data_en   = hit;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          cpu_stall = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        idle_rd;

  assign idle_rd = (state_q == IDLE) & cpu_re & ~cpu_we;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (idle_rd &  hit) hit_cnt_d  = hit_cnt_q + 32'd1;
    if (idle_rd & ~hit) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: misses, hits, write-through, conflicts, mid-transaction reset.
// Build with DCACHE_STATS_EN defined to also check the hit/miss counters.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dcache_wt #(.IDX_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One stalled transaction: detect cycle, n_wait cycles of mem_req without ack, then the ack cycle.
  task automatic mem_txn(input string nm, input logic [31:0] addr, input logic we,
                         input logic [31:0] wd, input int n_wait, input logic [31:0] rd);
    int stalls;
    stalls    = 0;
    cpu_addr  = addr;
    cpu_we    = we;
    cpu_re    = !we;
    cpu_wdata = wd;
    @(negedge clk);
    if (cpu_stall) stalls++;
    check({nm, " detect rdata"}, cpu_rdata, 32'h0);
    check({nm, " detect mem_req"}, {31'b0, mem_req}, 32'h0);
    step();
    for (int i = 0; i < n_wait; i++) begin
      @(negedge clk);
      if (cpu_stall) stalls++;
      check({nm, " mem_req"}, {31'b0, mem_req}, 32'h1);
      check({nm, " mem_we"}, {31'b0, mem_we}, {31'b0, we});
      check({nm, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
      if (we) check({nm, " mem_wdata"}, mem_wdata, wd);
      step();
    end
    mem_ack   = 1'b1;
    mem_rdata = we ? 32'hDEAD_BEEF : rd;
    @(negedge clk);
    check({nm, " ack stall"}, {31'b0, cpu_stall}, 32'h0);
    check({nm, " ack rdata"}, cpu_rdata, we ? 32'h0 : rd);
    check({nm, " stall cycles"}, stalls, 1 + n_wait);
    step();
    mem_ack = 1'b0;
    cpu_re  = 1'b0;
    cpu_we  = 1'b0;
    @(negedge clk);
    check({nm, " req cleared"}, {31'b0, mem_req}, 32'h0);
    step();
  endtask

  task automatic hit_load(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    cpu_addr = addr;
    cpu_re   = 1'b1;
    cpu_we   = 1'b0;
    @(negedge clk);
    check({nm, " hit stall"}, {31'b0, cpu_stall}, 32'h0);
    check({nm, " hit rdata"}, cpu_rdata, exp);
    step();
    cpu_re = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cpu_re    = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    step();
    step();
    @(negedge clk);
    check("reset mem_req", {31'b0, mem_req}, 32'h0);
    check("reset mem_we", {31'b0, mem_we}, 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    check("reset stall", {31'b0, cpu_stall}, 32'h0);
    check("reset rdata", cpu_rdata, 32'h0);
    step();
    reset = 1'b0;
    step();

    // Fill and re-hit
    mem_txn("ld54 miss", 32'h54, 1'b0, 32'h0, 3, 32'h15);
    hit_load("ld54", 32'h54, 32'h15);

    // Write-through hit updates the line
    mem_txn("st54", 32'h54, 1'b1, 32'hA, 2, 32'h0);
    hit_load("ld54 after st", 32'h54, 32'hA);

    // Write miss does not allocate
    mem_txn("st80", 32'h80, 1'b1, 32'h77, 1, 32'h0);
    mem_txn("ld80 miss", 32'h80, 1'b0, 32'h0, 1, 32'h99);

    // Index conflict on idx 1
    mem_txn("ld04 a", 32'h04, 1'b0, 32'h0, 1, 32'h11);
    mem_txn("ld44", 32'h44, 1'b0, 32'h0, 1, 32'h22);
    mem_txn("ld04 b", 32'h04, 1'b0, 32'h0, 1, 32'h33);
    hit_load("ld04", 32'h04, 32'h33);

    // Store wins over a simultaneous load, even on a hit
    cpu_addr  = 32'h04;
    cpu_wdata = 32'h44;
    cpu_re    = 1'b1;
    cpu_we    = 1'b1;
    @(negedge clk);
    check("re+we stall", {31'b0, cpu_stall}, 32'h1);
    check("re+we rdata", cpu_rdata, 32'h0);
    step();
    @(negedge clk);
    check("re+we mem_we", {31'b0, mem_we}, 32'h1);
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    cpu_re  = 1'b0;
    cpu_we  = 1'b0;
    step();
    hit_load("ld04 after re+we", 32'h04, 32'h44);

    // Stray ack while idle
    mem_ack = 1'b1;
    @(negedge clk);
    check("idle ack stall", {31'b0, cpu_stall}, 32'h0);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check("idle ack mem_req", {31'b0, mem_req}, 32'h0);
    step();
    hit_load("ld04 after idle ack", 32'h04, 32'h44);

    // Reset in the middle of a read miss
    cpu_addr = 32'h100;
    cpu_re   = 1'b1;
    step();
    @(negedge clk);
    check("pre-reset mem_req", {31'b0, mem_req}, 32'h1);
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async reset mem_req", {31'b0, mem_req}, 32'h0);
    cpu_re = 1'b0;
    step();
    reset   = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    check("late ack stall", {31'b0, cpu_stall}, 32'h0);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    check("late ack mem_req", {31'b0, mem_req}, 32'h0);
`ifdef DCACHE_STATS_EN
    check("post-reset hit_cnt", hit_cnt, 32'h0);
    check("post-reset miss_cnt", miss_cnt, 32'h0);
`endif
    step();
    mem_txn("ld54 after reset", 32'h54, 1'b0, 32'h0, 1, 32'h5A);
    hit_load("ld54 refill a", 32'h54, 32'h5A);
    hit_load("ld54 refill b", 32'h54, 32'h5A);
    mem_txn("st54 late", 32'h54, 1'b1, 32'h6B, 1, 32'h0);
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    check("stats hit_cnt", hit_cnt, 32'd2);
    check("stats miss_cnt", miss_cnt, 32'd1);
`endif
    hit_load("ld54 final", 32'h54, 32'h6B);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
